// File: rtl/arb_tcp_bridge_if.sv
// Handshake bundle between the arbiter/core side and the TCP byte bridge.
// The master side drives the arbiter write and TCP backpressure inputs;
// the slave side (the bridge) drives readiness, status and the byte stream.
interface arb_tcp_bridge_if #(
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          EN;
  logic          ARB_WRITE_OUT;
  logic [31:0]   ARB_DATA_OUT;
  logic          ARB_READY_OUT;
  logic          FIFO_FULL;
  logic          FIFO_NEAR_FULL;
  logic          TCP_TX_FULL;
  logic          TCP_TX_WR;
  logic [7:0]    TCP_TX_DATA;
  logic [CW-1:0] FIFO_SIZE;
  logic [7:0]    LOST_WORD_CNT;

  modport master (
    output EN, ARB_WRITE_OUT, ARB_DATA_OUT, TCP_TX_FULL,
    input  ARB_READY_OUT, FIFO_FULL, FIFO_NEAR_FULL, TCP_TX_WR,
           TCP_TX_DATA, FIFO_SIZE, LOST_WORD_CNT
  );

  modport slave (
    input  EN, ARB_WRITE_OUT, ARB_DATA_OUT, TCP_TX_FULL,
    output ARB_READY_OUT, FIFO_FULL, FIFO_NEAR_FULL, TCP_TX_WR,
           TCP_TX_DATA, FIFO_SIZE, LOST_WORD_CNT
  );
endinterface

// File: rtl/arb_tcp_bridge.sv
// Arbiter-to-TCP bridge: buffers 32-bit arbiter words in a block-RAM FIFO and
// serialises each word little-endian into four bytes for the TCP transmit FIFO.
// Words arriving while the FIFO is full are dropped and counted (saturating).
module arb_tcp_bridge #(
  parameter int DEPTH           = 1024,
  parameter int NEAR_FULL_LEVEL = 768
) (
  input  logic              BUS_CLK,
  input  logic              BUS_RST,
  arb_tcp_bridge_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NEAR_C  = CW'(NEAR_FULL_LEVEL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rdata_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_d;
  logic [7:0]    lost_q;
  logic [31:0]   shift_q;
  logic [31:0]   shift_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  state_t        state_q;
  state_t        state_d;

  logic          full_s;
  logic          wr_s;
  logic          drop_s;
  logic          pop_s;
  logic          tx_wr_s;

  // Status flags come straight from the registered fill level.
  assign full_s             = (fill_q == DEPTH_C);
  assign wr_s               = bus.ARB_WRITE_OUT & ~full_s;
  assign drop_s             = bus.ARB_WRITE_OUT & full_s;

  assign bus.ARB_READY_OUT  = ~full_s;
  assign bus.FIFO_FULL      = full_s;
  assign bus.FIFO_NEAR_FULL = (fill_q >= NEAR_C);
  assign bus.FIFO_SIZE      = fill_q;
  assign bus.LOST_WORD_CNT  = lost_q;
  assign bus.TCP_TX_WR      = tx_wr_s;
  assign bus.TCP_TX_DATA    = shift_q[{idx_q, 3'b000} +: 8];

  // Word storage: no reset so it maps onto block RAM; read is registered.
  // A pop never targets the slot being written, since that needs a full FIFO.
  always_ff @(posedge BUS_CLK) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= bus.ARB_DATA_OUT;
    end
    if (pop_s) begin
      rdata_q <= mem_q[rd_ptr_q];
    end
  end

  // Fill level next state: a simultaneous write and pop leaves it unchanged.
  always_comb begin
    fill_d = fill_q;
    case ({wr_s, pop_s})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Pointers, fill level and saturating lost-word counter.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      lost_q   <= 8'd0;
    end else begin
      if (wr_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      fill_q <= fill_d;
      if (drop_s && (lost_q != 8'hFF)) begin
        lost_q <= lost_q + 8'd1;
      end
    end
  end

  // Read FSM registers; reset discards any partially sent word.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Read FSM next state: pop in IDLE, capture RAM in LOAD, emit bytes in SEND.
  // EN is only sampled in IDLE, so a word once popped is always completed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    tx_wr_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.EN && (fill_q != '0)) begin
          pop_s   = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        shift_d = rdata_q;
        idx_d   = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (!bus.TCP_TX_FULL) begin
          tx_wr_s = 1'b1;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_arb_tcp_bridge.sv
// Scoreboard bench for arb_tcp_bridge: stimulus pushes the expected byte
// stream into a queue, a negedge monitor pops and compares every TCP byte.
module tb_arb_tcp_bridge;
  localparam int DEPTH = 16;
  localparam int NF    = 12;

  logic BUS_CLK;
  logic BUS_RST;

  arb_tcp_bridge_if #(.DEPTH(DEPTH)) bus ();

  arb_tcp_bridge #(.DEPTH(DEPTH), .NEAR_FULL_LEVEL(NF)) dut (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .bus     (bus.slave)
  );

  int         total = 0;
  int         bad = 0;
  int         bytes_seen = 0;
  logic [7:0] exp_q[$];
  bit         stop_rand;

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  // Watchdog so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every accepted byte must match the head of the expected queue.
  always @(negedge BUS_CLK) begin
    if (!BUS_RST && bus.TCP_TX_WR) begin
      total++;
      bytes_seen++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL byte_unexpected actual=%02h required=none", bus.TCP_TX_DATA);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.TCP_TX_DATA !== e) begin
          bad++;
          $display("FAIL byte_data actual=%02h required=%02h", bus.TCP_TX_DATA, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  // One-cycle write strobe; called #1 after a rising edge, returns #1 after the next.
  task automatic send_word(input logic [31:0] w, input bit accept);
    bus.ARB_DATA_OUT  = w;
    bus.ARB_WRITE_OUT = 1'b1;
    if (accept) push_word(w);
    @(posedge BUS_CLK);
    #1;
    bus.ARB_WRITE_OUT = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge BUS_CLK);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s actual=%0d_left required=0_left", name, exp_q.size());
    end
  endtask

  task automatic wait_bytes(input string name, input int target, input int budget);
    int n = 0;
    while (bytes_seen < target && n < budget) begin
      @(posedge BUS_CLK);
      n++;
    end
    total++;
    if (bytes_seen < target) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, bytes_seen, target);
    end
  endtask

  task automatic do_reset();
    BUS_RST = 1'b1;
    bus.ARB_WRITE_OUT = 1'b0;
    repeat (2) @(posedge BUS_CLK);
    #1;
    BUS_RST = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int b0;
    int b1;
    logic [31:0] w;

    BUS_RST           = 1'b1;
    bus.EN            = 1'b0;
    bus.ARB_WRITE_OUT = 1'b0;
    bus.ARB_DATA_OUT  = 32'd0;
    bus.TCP_TX_FULL   = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.ARB_READY_OUT), 32'd1);
    chk("rst_full", 32'(bus.FIFO_FULL), 32'd0);
    chk("rst_near", 32'(bus.FIFO_NEAR_FULL), 32'd0);
    chk("rst_size", 32'(bus.FIFO_SIZE), 32'd0);
    chk("rst_lost", 32'(bus.LOST_WORD_CNT), 32'd0);
    chk("rst_wr", 32'(bus.TCP_TX_WR), 32'd0);
    chk("rst_data", 32'(bus.TCP_TX_DATA), 32'd0);
    do_reset();

    // Test 1: single word, latency and four consecutive byte strobes.
    bus.EN = 1'b1;
    send_word(32'hDDCCBBAA, 1'b1);
    chk("t1_size_after_write", 32'(bus.FIFO_SIZE), 32'd1);
    @(posedge BUS_CLK); #1;
    chk("t1_size_after_pop", 32'(bus.FIFO_SIZE), 32'd0);
    chk("t1_wr_load", 32'(bus.TCP_TX_WR), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge BUS_CLK); #1;
      chk("t1_wr_burst", 32'(bus.TCP_TX_WR), 32'd1);
    end
    @(posedge BUS_CLK); #1;
    chk("t1_wr_end", 32'(bus.TCP_TX_WR), 32'd0);
    chk("t1_queue", 32'(exp_q.size()), 32'd0);
    chk("t1_size_end", 32'(bus.FIFO_SIZE), 32'd0);
    chk("t1_lost", 32'(bus.LOST_WORD_CNT), 32'd0);

    // Test 2: fill with EN=0, near-full/full flags, saturating drops, then drain.
    do_reset();
    bus.EN = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send_word(32'hC0DE0000 + 32'(i) * 32'h00010101, 1'b1);
      chk("t2_size", 32'(bus.FIFO_SIZE), 32'(i + 1));
      chk("t2_near", 32'(bus.FIFO_NEAR_FULL), 32'((i + 1) >= NF));
      chk("t2_full", 32'(bus.FIFO_FULL), 32'((i + 1) == DEPTH));
      chk("t2_ready", 32'(bus.ARB_READY_OUT), 32'((i + 1) != DEPTH));
    end
    for (int i = 0; i < 300; i++) begin
      bus.ARB_DATA_OUT  = 32'hDEAD0000 + 32'(i);
      bus.ARB_WRITE_OUT = 1'b1;
      @(posedge BUS_CLK); #1;
      if (i == 0) chk("t2_lost_first", 32'(bus.LOST_WORD_CNT), 32'd1);
    end
    bus.ARB_WRITE_OUT = 1'b0;
    chk("t2_lost_sat", 32'(bus.LOST_WORD_CNT), 32'd255);
    chk("t2_size_full", 32'(bus.FIFO_SIZE), 32'(DEPTH));
    bus.EN = 1'b1;
    wait_drain("t2_drain", DEPTH * 8 + 20);
    repeat (3) @(posedge BUS_CLK); #1;
    chk("t2_size_end", 32'(bus.FIFO_SIZE), 32'd0);
    chk("t2_lost_end", 32'(bus.LOST_WORD_CNT), 32'd255);

    // Test 3: backpressure held for 10 cycles while byte index 2 is presented.
    do_reset();
    bus.EN = 1'b1;
    b0 = bytes_seen;
    send_word(32'h04030201, 1'b1);
    wait_bytes("t3_reach_b2", b0 + 2, 20);
    #1;
    bus.TCP_TX_FULL = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge BUS_CLK);
      chk("t3_stall_wr", 32'(bus.TCP_TX_WR), 32'd0);
      chk("t3_stall_data", 32'(bus.TCP_TX_DATA), 32'h03);
    end
    @(posedge BUS_CLK); #1;
    bus.TCP_TX_FULL = 1'b0;
    wait_drain("t3_drain", 20);
    repeat (5) @(posedge BUS_CLK); #1;
    chk("t3_byte_count", 32'(bytes_seen - b0), 32'd4);

    // Test 4: 3*DEPTH words with random gaps and random backpressure (wraps).
    do_reset();
    bus.EN = 1'b1;
    stop_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          w = 32'h5A000000 + 32'(i) * 32'h00010103;
          send_word(w, 1'b1);
          repeat ($urandom_range(8, 12)) @(posedge BUS_CLK);
          #1;
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge BUS_CLK); #1;
          bus.TCP_TX_FULL = ($urandom_range(0, 3) == 0);
        end
      end
    join
    bus.TCP_TX_FULL = 1'b0;
    wait_drain("t4_drain", DEPTH * 10 + 50);
    repeat (3) @(posedge BUS_CLK); #1;
    chk("t4_lost", 32'(bus.LOST_WORD_CNT), 32'd0);
    chk("t4_size", 32'(bus.FIFO_SIZE), 32'd0);

    // Test 5: EN dropped during byte 1; the word completes, nothing more pops.
    do_reset();
    bus.EN = 1'b0;
    for (int i = 0; i < 5; i++) send_word(32'h11223300 + 32'(i), 1'b1);
    b0 = bytes_seen;
    bus.EN = 1'b1;
    wait_bytes("t5_reach_b1", b0 + 1, 20);
    #1;
    bus.EN = 1'b0;
    repeat (20) @(posedge BUS_CLK); #1;
    chk("t5_bytes", 32'(bytes_seen - b0), 32'd4);
    chk("t5_size", 32'(bus.FIFO_SIZE), 32'd4);
    chk("t5_wr_idle", 32'(bus.TCP_TX_WR), 32'd0);
    bus.EN = 1'b1;
    wait_drain("t5_drain", 60);
    repeat (3) @(posedge BUS_CLK); #1;
    chk("t5_size_end", 32'(bus.FIFO_SIZE), 32'd0);

    // Test 6: asynchronous reset mid-SEND with 10 words queued.
    do_reset();
    bus.EN = 1'b0;
    for (int i = 0; i < 10; i++) send_word(32'hA5A50000 + 32'(i), 1'b1);
    b0 = bytes_seen;
    bus.EN = 1'b1;
    wait_bytes("t6_reach_b2", b0 + 2, 20);
    #2;
    BUS_RST = 1'b1;
    #1;
    chk("t6_wr_async", 32'(bus.TCP_TX_WR), 32'd0);
    chk("t6_size", 32'(bus.FIFO_SIZE), 32'd0);
    chk("t6_ready", 32'(bus.ARB_READY_OUT), 32'd1);
    chk("t6_data", 32'(bus.TCP_TX_DATA), 32'd0);
    exp_q.delete();
    @(posedge BUS_CLK); #1;
    BUS_RST = 1'b0;
    b1 = bytes_seen;
    repeat (30) @(posedge BUS_CLK); #1;
    chk("t6_no_stale", 32'(bytes_seen - b1), 32'd0);
    send_word(32'h0D0C0B0A, 1'b1);
    wait_drain("t6_drain", 20);
    repeat (3) @(posedge BUS_CLK); #1;
    chk("t6_size_end", 32'(bus.FIFO_SIZE), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arb_tcp_bridge.md
Name: arb_tcp_bridge

Overview:
- Sits directly downstream of the rrp_arbiter in the readout top level.
- Accepts 32-bit words on the arbiter write handshake and buffers them in an internal FIFO.
- Drives ARB_READY_OUT, FIFO_FULL and FIFO_NEAR_FULL back to the core.
- Serialises each buffered word into four bytes for the 8-bit TCP transmit FIFO, with backpressure and lost-word accounting.

Parameters:
DEPTH, 1024, FIFO depth in 32-bit words; power of two, minimum 4.
NEAR_FULL_LEVEL, 768, fill level (words) at or above which FIFO_NEAR_FULL asserts; must satisfy 1 ≤ NEAR_FULL_LEVEL < DEPTH.

Ports:
BUS_CLK  in  1  single clock for all logic.
BUS_RST  in  1  asynchronous, active-high reset.
EN  in  1  enables popping of new words towards TCP.
ARB_WRITE_OUT  in  1  arbiter write strobe.
ARB_DATA_OUT  in  32  arbiter data word.
ARB_READY_OUT  out  1  bridge can accept a word.
FIFO_FULL  out  1  fill level == DEPTH.
FIFO_NEAR_FULL  out  1  fill level >= NEAR_FULL_LEVEL.
TCP_TX_FULL  in  1  downstream byte FIFO cannot accept data.
TCP_TX_WR  out  1  byte write strobe.
TCP_TX_DATA  out  8  byte data.
FIFO_SIZE  out  clog2(DEPTH)+1  current fill level in words.
LOST_WORD_CNT  out  8  words dropped because the FIFO was full.

Behaviour:
- Reset (async assert, clears on the next edge after release):
  - fill level, read/write pointers, LOST_WORD_CNT, TCP_TX_WR and TCP_TX_DATA all 0.
  - FSM goes to IDLE; any partially sent word is discarded.
  - ARB_READY_OUT=1, FIFO_FULL=0, FIFO_NEAR_FULL=0 once reset is asserted.
- Write side:
  - ARB_READY_OUT = ~FIFO_FULL, derived combinationally from the registered fill level.
  - A word is accepted on a rising edge where ARB_WRITE_OUT & ARB_READY_OUT; it is stored at the write pointer and the pointer increments mod DEPTH.
  - ARB_WRITE_OUT while full: word dropped; LOST_WORD_CNT increments, saturating at 255 (never wraps); LOST_WORD_CNT is cleared only by reset.
  - FIFO_FULL, FIFO_NEAR_FULL and FIFO_SIZE are combinational from the registered fill level, so they update the cycle after the write or pop.
- Fill level:
  - +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
  - A simultaneous write and pop while full is impossible, because a write requires ~FIFO_FULL.
- Read FSM, states IDLE, LOAD, SEND:
  - IDLE: if EN & fill level>0, pop (read pointer +1 mod DEPTH, synchronous RAM read issued) -> LOAD.
  - LOAD: capture the RAM output into a 32-bit shift register, byte index=0 -> SEND.
  - SEND: TCP_TX_WR = ~TCP_TX_FULL (combinational gate on the registered state).
    - TCP_TX_DATA = shift register byte[index], little-endian: [7:0] first, [31:24] last.
    - Byte accepted when TCP_TX_WR=1; index increments.
    - TCP_TX_FULL=1: TCP_TX_WR=0, data held, no index change.
    - After byte 3 is accepted -> IDLE.
- EN deasserted mid-word: the current word completes (no partial words ever emitted); no new pop occurs.
- Throughput: at most one word per 6 cycles (IDLE, LOAD, 4×SEND).
- Latency: word written at edge N is visible at edge N+1; first TCP_TX_WR is at cycle N+3 when EN=1 and TCP_TX_FULL=0.
- Pointer wrap: the read and write pointers wrap independently; data order is preserved across the wrap.
- Memory: single-clock, inferable as block RAM, with write-first/read-old behaviour irrelevant because the same address is never read and written in one cycle while non-empty.

Test Plan:
1. Single word 0xDDCCBBAA, EN=1, TCP_TX_FULL=0 -> TCP_TX_WR pulses on 4 consecutive cycles with 0xAA, 0xBB, 0xCC, 0xDD; FIFO_SIZE returns to 0; LOST_WORD_CNT=0.
2. EN=0, write DEPTH words -> FIFO_FULL=1, ARB_READY_OUT=0; FIFO_NEAR_FULL asserts after word NEAR_FULL_LEVEL; 300 further writes -> LOST_WORD_CNT=255 (saturated); FIFO contents unchanged.
3. Single word 0x04030201 with TCP_TX_FULL held high for 10 cycles during byte index 2 -> TCP_TX_WR=0 and TCP_TX_DATA=0x03 held throughout; after release the bytes continue 0x03 then 0x04; no duplicated byte.
4. Stream of 3×DEPTH incrementing words with random TCP_TX_FULL and random arbiter gaps, never full -> byte stream equals the words in order, little-endian, across pointer wrap; LOST_WORD_CNT=0.
5. EN dropped during byte 1 of a word, with 5 words queued -> bytes 1–3 of that word complete, then no TCP_TX_WR; FIFO_SIZE=4 until EN returns.
6. BUS_RST asserted mid-SEND with 10 words queued -> TCP_TX_WR=0 immediately (asynchronous); FIFO_SIZE=0, ARB_READY_OUT=1; after release no stale bytes are emitted.
